agu_seq: RTL

AGU_SEQ -- requirements
Module: agu_seq

---
 rtl/agu_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/agu_seq.sv
// agu_seq: sequencer that drives a 4-deep address generation unit (AGU)
// through a job: clears it, then streams one memory request per AGU element
// until the AGU reports the end of its nest (all z flags) a total of l4+1
// times. An optional abort or reset drops the job without a done pulse.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   start, abort           job request (IDLE only); job termination (CLR/RUN)
//   l4                     outer repetitions minus one, latched on start
//   agu_addr, agu_z0..3    AGU current address and step-qualified zero flags
//   agu_clr, agu_step      AGU clear / advance
//   req_valid, req_ready   memory request handshake
//   req_addr               request address (pass-through of agu_addr)
//   busy, done             job in progress; one-cycle completion pulse
//   elem_cnt               elements accepted in the current/last job
//
// state | meaning
// IDLE  | waiting for start
// CLR   | one-cycle AGU clear before streaming
// RUN   | issuing requests, one per accepted beat
// DONE  | one-cycle completion pulse
module agu_seq #(
  parameter int BWADDR   = 21,
  parameter int BWLENGTH = 8,
  parameter int BWCOUNT  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [BWLENGTH-1:0] l4,
  input  logic [BWADDR-1:0]   agu_addr,
  input  logic                agu_z0,
  input  logic                agu_z1,
  input  logic                agu_z2,
  input  logic                agu_z3,
  output logic                agu_clr,
  output logic                agu_step,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [BWADDR-1:0]   req_addr,
  output logic                busy,
  output logic                done,
  output logic [BWCOUNT-1:0]  elem_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state;
  logic [BWLENGTH-1:0] i4;
  logic                run_q;
  logic                beat;
  logic                z_all;

  // run_q is the registered RUN flag; rst gates it so no beat can be
  // accepted while the AGU is being re-initialised.
  assign req_valid = run_q & ~rst;
  assign agu_step  = req_valid & req_ready;
  assign beat      = agu_step;
  assign req_addr  = agu_addr;
  assign z_all     = agu_z0 & agu_z1 & agu_z2 & agu_z3;

  // Clear the AGU during reset, in CLR, and in the cycle an abort is taken.
  assign agu_clr = rst | (state == S_CLR) | (abort & (state == S_RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      i4       <= '0;
      elem_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CLR;
            i4       <= l4;
            elem_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        S_CLR: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_RUN;
            run_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (beat) begin
            elem_cnt <= elem_cnt + BWCOUNT'(1);
          end
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            run_q <= 1'b0;
          end else if (beat && z_all) begin
            if (i4 == '0) begin
              state <= S_DONE;
              run_q <= 1'b0;
              done  <= 1'b1;
            end else begin
              i4 <= i4 - BWLENGTH'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          run_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
